// File: rtl/conbus_arb_wd_pkg.sv
// Shared definitions for the conbus arbiter family.
//   - Default watchdog / counter sizing reused by conbus top levels.
//   - gnt_width(): index width needed for a given number of masters.
//   - rr_next():   round-robin successor index with wrap.
package conbus_arb_wd_pkg;

    localparam int CONBUS_NUM_MASTERS_DEF = 5;
    localparam int CONBUS_TIMEOUT_DEF     = 1024;
    localparam int CONBUS_TO_W_DEF        = 11;
    localparam int CONBUS_CNT_W_DEF       = 16;

    function automatic int gnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Index reached by stepping 'step' places after 'cur' in a ring of n.
    function automatic int rr_next(input int cur, input int step, input int n);
        return (cur + step) % n;
    endfunction

endpackage

// File: rtl/conbus_arb_wd_if.sv
// Arbiter-facing bundle of the shared Wishbone interconnect.
//   req     : per-master cyc
//   bus_stb : stb of the granted master (after the mux)
//   bus_ack : OR of all slave acks
//   gnt     : registered owner index
//   gnt_oh  : one-hot decode of gnt
//   bus_err : one-cycle timeout error towards the owner
// Modport 'slave' is the arbiter side, 'master' the interconnect side.
interface conbus_arb_wd_if #(
    parameter int NUM_MASTERS = 5,
    parameter int GNT_W       = 3
);
    logic [NUM_MASTERS-1:0] req;
    logic                   bus_stb;
    logic                   bus_ack;
    logic [GNT_W-1:0]       gnt;
    logic [NUM_MASTERS-1:0] gnt_oh;
    logic                   bus_err;

    modport slave (
        input  req,
        input  bus_stb,
        input  bus_ack,
        output gnt,
        output gnt_oh,
        output bus_err
    );

    modport master (
        output req,
        output bus_stb,
        output bus_ack,
        input  gnt,
        input  gnt_oh,
        input  bus_err
    );
endinterface

// File: rtl/conbus_rr_pick.sv
// Combinational rotate-priority encoder.
//   req_i   : request vector
//   cur_i   : current owner; search starts at cur_i+1 and wraps
//   excl_i  : drop cur_i from the candidate list (it would otherwise be last)
//   nxt_o   : first requesting index found (cur_i when none)
//   found_o : a candidate was found
module conbus_rr_pick
    import conbus_arb_wd_pkg::*;
#(
    parameter int NUM_MASTERS = 5,
    parameter int GNT_W       = 3
) (
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic [GNT_W-1:0]       cur_i,
    input  logic                   excl_i,
    output logic [GNT_W-1:0]       nxt_o,
    output logic                   found_o
);

    always_comb begin
        logic [GNT_W-1:0] idx;
        idx     = '0;
        nxt_o   = cur_i;
        found_o = 1'b0;
        // Step k = NUM_MASTERS lands back on cur_i, making the owner the last candidate.
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            idx = GNT_W'(rr_next(int'(cur_i), k, NUM_MASTERS));
            if (!found_o && req_i[idx] && !(excl_i && (k == NUM_MASTERS))) begin
                found_o = 1'b1;
                nxt_o   = idx;
            end
        end
    end

endmodule

// File: rtl/conbus_arb_wd.sv
// Round-robin Wishbone bus arbiter with per-transaction watchdog.
// Ownership is held for the whole cyc of the owner; if the owner's strobe
// stays unacknowledged for TIMEOUT cycles an error pulse is issued and
// ownership is forcibly rotated away from it.
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   bus (slave)        : req/bus_stb/bus_ack in, gnt/gnt_oh/bus_err out
//   to_clr             : synchronous clear of to_count and to_master
//   to_master          : index of the master that last timed out
//   to_count           : saturating count of timeout events
module conbus_arb_wd
    import conbus_arb_wd_pkg::*;
#(
    parameter int NUM_MASTERS = CONBUS_NUM_MASTERS_DEF,
    parameter int GNT_W       = 3,
    parameter int TIMEOUT     = CONBUS_TIMEOUT_DEF,
    parameter int TO_W        = CONBUS_TO_W_DEF,
    parameter int CNT_W       = CONBUS_CNT_W_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    conbus_arb_wd_if.slave    bus,
    input  logic              to_clr,
    output logic [GNT_W-1:0]  to_master,
    output logic [CNT_W-1:0]  to_count
);

    localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT - 1);

    logic [GNT_W-1:0]       gnt_q, gnt_d;
    logic [TO_W-1:0]        wd_q, wd_d;
    logic                   err_q;
    logic [GNT_W-1:0]       to_master_q, to_master_d;
    logic [CNT_W-1:0]       to_count_q, to_count_d;

    logic                   own_req;
    logic                   wd_cond;
    logic                   timeout;
    logic                   release_own;
    logic [GNT_W-1:0]       pick_idx;
    logic                   pick_found;
    logic [NUM_MASTERS-1:0] gnt_oh;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign own_req = bus.req[gnt_q];
    assign wd_cond = own_req & bus.bus_stb & ~bus.bus_ack;
    // An ack in the limit cycle removes wd_cond, so ack always beats the timeout.
    assign timeout = (TIMEOUT != 0) && wd_cond && (wd_q == WD_LAST);

    // Ownership is only re-evaluated when the owner drops cyc or times out.
    assign release_own = ~own_req | timeout;

    conbus_rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .GNT_W       (GNT_W)
    ) u_pick (
        .req_i   (bus.req),
        .cur_i   (gnt_q),
        .excl_i  (timeout),
        .nxt_o   (pick_idx),
        .found_o (pick_found)
    );

    // No candidate (idle bus, or a timed-out sole requester): hold gnt, never park.
    always_comb begin
        gnt_d = gnt_q;
        if (release_own && pick_found) begin
            gnt_d = pick_idx;
        end
    end

    always_comb begin
        wd_d = wd_q + TO_W'(1);
        if ((TIMEOUT == 0) || !wd_cond || timeout || (gnt_d != gnt_q)) begin
            wd_d = '0;
        end
    end

    // Clear wins over a coincident timeout; bus_err still pulses.
    always_comb begin
        to_master_d = to_master_q;
        to_count_d  = to_count_q;
        if (to_clr) begin
            to_master_d = '0;
            to_count_d  = '0;
        end else if (timeout) begin
            to_master_d = gnt_q;
            to_count_d  = sat_inc(to_count_q);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            gnt_q       <= '0;
            wd_q        <= '0;
            err_q       <= 1'b0;
            to_master_q <= '0;
            to_count_q  <= '0;
        end else begin
            gnt_q       <= gnt_d;
            wd_q        <= wd_d;
            err_q       <= timeout;
            to_master_q <= to_master_d;
            to_count_q  <= to_count_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            gnt_oh[i] = (gnt_q == GNT_W'(i));
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.gnt_oh  = gnt_oh;
    assign bus.bus_err = err_q;
    assign to_master   = to_master_q;
    assign to_count    = to_count_q;

endmodule

// File: tb/tb_conbus_arb_wd.sv
// Directed bench for conbus_arb_wd: a vector table for arbitration and
// burst holding, plus hand-written sequences for watchdog, saturation,
// clear priority and asynchronous reset.
module tb_conbus_arb_wd;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    conbus_arb_wd_if #(.NUM_MASTERS(5), .GNT_W(3)) bm ();
    conbus_arb_wd_if #(.NUM_MASTERS(5), .GNT_W(3)) bs ();
    conbus_arb_wd_if #(.NUM_MASTERS(5), .GNT_W(3)) bo ();

    logic        clr_m, clr_s;
    logic [2:0]  tm_m, tm_s, tm_o;
    logic [15:0] tc_m;
    logic [3:0]  tc_s, tc_o;

    conbus_arb_wd #(.NUM_MASTERS(5), .GNT_W(3), .TIMEOUT(16), .TO_W(5), .CNT_W(16)) u_main (
        .sys_clk(clk), .sys_rst_n(rst_n), .bus(bm), .to_clr(clr_m),
        .to_master(tm_m), .to_count(tc_m));

    conbus_arb_wd #(.NUM_MASTERS(5), .GNT_W(3), .TIMEOUT(2), .TO_W(2), .CNT_W(4)) u_sat (
        .sys_clk(clk), .sys_rst_n(rst_n), .bus(bs), .to_clr(clr_s),
        .to_master(tm_s), .to_count(tc_s));

    conbus_arb_wd #(.NUM_MASTERS(5), .GNT_W(3), .TIMEOUT(0), .TO_W(1), .CNT_W(4)) u_off (
        .sys_clk(clk), .sys_rst_n(rst_n), .bus(bo), .to_clr(clr_s),
        .to_master(tm_o), .to_count(tc_o));

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        logic [4:0] req;
        logic       stb;
        logic       ack;
        logic [2:0] gnt;
        logic       err;
    } vec_t;

    vec_t tbl [25];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic [4:0] r, input logic s, input logic a, input logic c);
        @(negedge clk);
        bm.req = r; bm.bus_stb = s; bm.bus_ack = a; clr_m = c;
        @(posedge clk);
        #1;
    endtask

    task automatic step_s(input logic [4:0] r, input logic s, input logic a);
        @(negedge clk);
        bs.req = r; bs.bus_stb = s; bs.bus_ack = a;
        bo.req = r; bo.bus_stb = s; bo.bus_ack = a;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        bm.req = '0; bm.bus_stb = 1'b0; bm.bus_ack = 1'b0; clr_m = 1'b0;
        bs.req = '0; bs.bus_stb = 1'b0; bs.bus_ack = 1'b0; clr_s = 1'b0;
        bo.req = '0; bo.bus_stb = 1'b0; bo.bus_ack = 1'b0;

        // Round robin 1,2,4,1 then a burst by master 2 with a stb gap.
        tbl[0]  = '{5'b10110, 1'b0, 1'b0, 3'd1, 1'b0};
        tbl[1]  = '{5'b10110, 1'b0, 1'b0, 3'd1, 1'b0};
        tbl[2]  = '{5'b10100, 1'b0, 1'b0, 3'd2, 1'b0};
        tbl[3]  = '{5'b10110, 1'b0, 1'b0, 3'd2, 1'b0};
        tbl[4]  = '{5'b10010, 1'b0, 1'b0, 3'd4, 1'b0};
        tbl[5]  = '{5'b10110, 1'b0, 1'b0, 3'd4, 1'b0};
        tbl[6]  = '{5'b00110, 1'b0, 1'b0, 3'd1, 1'b0};
        tbl[7]  = '{5'b00110, 1'b0, 1'b0, 3'd1, 1'b0};
        tbl[8]  = '{5'b01100, 1'b0, 1'b0, 3'd2, 1'b0};
        tbl[9]  = '{5'b01100, 1'b1, 1'b1, 3'd2, 1'b0};
        tbl[10] = '{5'b01100, 1'b1, 1'b0, 3'd2, 1'b0};
        tbl[11] = '{5'b01100, 1'b1, 1'b1, 3'd2, 1'b0};
        tbl[12] = '{5'b01100, 1'b1, 1'b1, 3'd2, 1'b0};
        tbl[13] = '{5'b01100, 1'b0, 1'b0, 3'd2, 1'b0};
        tbl[14] = '{5'b01100, 1'b0, 1'b0, 3'd2, 1'b0};
        tbl[15] = '{5'b01100, 1'b0, 1'b0, 3'd2, 1'b0};
        tbl[16] = '{5'b01100, 1'b1, 1'b1, 3'd2, 1'b0};
        tbl[17] = '{5'b01100, 1'b1, 1'b1, 3'd2, 1'b0};
        tbl[18] = '{5'b01100, 1'b1, 1'b1, 3'd2, 1'b0};
        tbl[19] = '{5'b01100, 1'b1, 1'b1, 3'd2, 1'b0};
        tbl[20] = '{5'b01100, 1'b1, 1'b1, 3'd2, 1'b0};
        tbl[21] = '{5'b01000, 1'b0, 1'b0, 3'd3, 1'b0};
        tbl[22] = '{5'b00000, 1'b0, 1'b0, 3'd3, 1'b0};
        tbl[23] = '{5'b00000, 1'b0, 1'b0, 3'd3, 1'b0};
        tbl[24] = '{5'b00010, 1'b0, 1'b0, 3'd1, 1'b0};

        // Reset state.
        #12;
        chk("rst_gnt",    32'(bm.gnt),    32'd0);
        chk("rst_gnt_oh", 32'(bm.gnt_oh), 32'b00001);
        chk("rst_err",    32'(bm.bus_err), 32'd0);
        chk("rst_tocnt",  32'(tc_m),      32'd0);
        chk("rst_tomst",  32'(tm_m),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 10; k++) begin
            step(5'b00000, 1'b0, 1'b0, 1'b0);
            chk("idle_gnt", 32'(bm.gnt), 32'd0);
        end

        for (int i = 0; i < 25; i++) begin
            step(tbl[i].req, tbl[i].stb, tbl[i].ack, 1'b0);
            chk($sformatf("tbl%0d_gnt", i),    32'(bm.gnt),     32'(tbl[i].gnt));
            chk($sformatf("tbl%0d_gnt_oh", i), 32'(bm.gnt_oh),  32'(1) << tbl[i].gnt);
            chk($sformatf("tbl%0d_err", i),    32'(bm.bus_err), 32'(tbl[i].err));
        end

        // Timeout with another requester: ownership moves to master 0.
        for (int k = 1; k <= 16; k++) begin
            step(5'b00011, 1'b1, 1'b0, 1'b0);
            chk("toA_err", 32'(bm.bus_err), 32'(k == 16));
            chk("toA_gnt", 32'(bm.gnt), (k == 16) ? 32'd0 : 32'd1);
        end
        chk("toA_tomst", 32'(tm_m), 32'd1);
        chk("toA_tocnt", 32'(tc_m), 32'd1);
        step(5'b00011, 1'b0, 1'b0, 1'b0);
        chk("toA_err_end", 32'(bm.bus_err), 32'd0);
        chk("toA_gnt_end", 32'(bm.gnt), 32'd0);

        // Sole requester times out twice: gnt held, watchdog restarts.
        step(5'b00010, 1'b0, 1'b0, 1'b0);
        chk("toB_gnt0", 32'(bm.gnt), 32'd1);
        for (int k = 1; k <= 32; k++) begin
            step(5'b00010, 1'b1, 1'b0, 1'b0);
            chk("toB_err", 32'(bm.bus_err), 32'((k == 16) || (k == 32)));
            chk("toB_gnt", 32'(bm.gnt), 32'd1);
        end
        chk("toB_tocnt", 32'(tc_m), 32'd3);
        chk("toB_tomst", 32'(tm_m), 32'd1);
        step(5'b00010, 1'b0, 1'b0, 1'b0);

        // Ack arriving in the 16th wait cycle beats the timeout.
        for (int k = 1; k <= 16; k++) begin
            step(5'b00010, 1'b1, (k == 16), 1'b0);
            chk("ackC_err", 32'(bm.bus_err), 32'd0);
        end
        step(5'b00010, 1'b0, 1'b0, 1'b0);
        chk("ackC_err_end", 32'(bm.bus_err), 32'd0);
        chk("ackC_tocnt",   32'(tc_m), 32'd3);

        // Asynchronous reset in the middle of a burst.
        step(5'b00010, 1'b1, 1'b1, 1'b0);
        step(5'b00010, 1'b1, 1'b1, 1'b0);
        chk("rstE_pre_gnt", 32'(bm.gnt), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rstE_gnt",    32'(bm.gnt),     32'd0);
        chk("rstE_gnt_oh", 32'(bm.gnt_oh),  32'b00001);
        chk("rstE_tocnt",  32'(tc_m),       32'd0);
        chk("rstE_tomst",  32'(tm_m),       32'd0);
        chk("rstE_err",    32'(bm.bus_err), 32'd0);
        @(negedge clk);
        bm.req = 5'b00010; bm.bus_stb = 1'b0; bm.bus_ack = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("rstE_rel_gnt", 32'(bm.gnt), 32'd0);
        @(posedge clk);
        #1;
        chk("rstE_after_gnt", 32'(bm.gnt), 32'd1);

        // Clear coincident with a timeout: clear wins, error still pulses.
        for (int k = 1; k <= 16; k++) begin
            step(5'b00010, 1'b1, 1'b0, (k == 16));
            chk("clrD_err", 32'(bm.bus_err), 32'(k == 16));
        end
        chk("clrD_tocnt", 32'(tc_m), 32'd0);
        chk("clrD_tomst", 32'(tm_m), 32'd0);
        step(5'b00010, 1'b0, 1'b0, 1'b0);
        chk("clrD_err_end", 32'(bm.bus_err), 32'd0);

        // Saturation (TIMEOUT=2, 4-bit counter) and disabled watchdog.
        for (int k = 1; k <= 32; k++) begin
            step_s(5'b00001, 1'b1, 1'b0);
            chk("satF_err", 32'(bs.bus_err), 32'((k % 2) == 0));
            chk("offF_err", 32'(bo.bus_err), 32'd0);
            if (k == 30) chk("satF_cnt15", 32'(tc_s), 32'd15);
        end
        chk("satF_cnt_hold", 32'(tc_s), 32'd15);
        chk("satF_gnt",      32'(bs.gnt), 32'd0);
        chk("offF_cnt",      32'(tc_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/conbus_arb_wd.md
Name: conbus_arb_wd

Overview:
- Round-robin bus arbiter with a per-transaction watchdog for the shared Wishbone interconnect.
- Drives the grant select of the conbus master multiplexer and holds ownership for a whole cycle (cyc high).
- If the owning master's strobe goes unacknowledged for TIMEOUT cycles, it issues an error pulse and forcibly rotates ownership, so a dead slave cannot lock the bus.

Parameters:
- NUM_MASTERS, 5, number of requesters (2..8).
- GNT_W, 3, grant index width; must satisfy 2**GNT_W >= NUM_MASTERS.
- TIMEOUT, 1024, cycles of unacknowledged strobe before error; 0 disables the watchdog.
- TO_W, 11, watchdog counter width; must hold TIMEOUT.
- CNT_W, 16, width of the timeout event counter.

Ports:
- sys_clk  in  1  system clock, all state on rising edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_MASTERS  per-master cyc_i.
- bus_stb  in  1  stb of the currently granted master (after the mux).
- bus_ack  in  1  OR of all slave acks.
- gnt  out  GNT_W  registered index of the owning master.
- gnt_oh  out  NUM_MASTERS  one-hot decode of gnt, combinational from the gnt register.
- bus_err  out  1  one-cycle pulse, routed to the owning master as err_o.
- to_master  out  GNT_W  index of the master that last timed out.
- to_count  out  CNT_W  saturating count of timeout events.
- to_clr  in  1  synchronous clear of to_count and to_master.

Behaviour:
- Reset values: gnt=0, gnt_oh=1 (bit 0), bus_err=0, to_master=0, to_count=0, watchdog=0.
- Ownership:
  - gnt changes only when req[gnt]==0 or a timeout fires in this cycle.
  - Otherwise gnt is held, including across bursts, stb gaps and cti changes.
- Arbitration, evaluated when ownership is released:
  - Search req starting at index (gnt+1) mod NUM_MASTERS, wrapping.
  - The first set bit becomes the new gnt at the next edge; latency is 1 cycle from the cyc drop.
  - Normal release: the current master is the last candidate, so it may re-win only if it is the sole requester.
  - Timeout release: the current master is excluded for that single decision. If no other master requests, gnt is held.
  - No requests at all: gnt holds its value. It is not parked to 0.
- Watchdog:
  - Counts when req[gnt] & bus_stb & !bus_ack.
  - Clears to 0 on bus_ack, on !bus_stb, on !req[gnt], or on any gnt change.
  - When the count equals TIMEOUT-1 and the counting condition still holds, that cycle is the timeout. At the next edge:
    - bus_err=1 for exactly one cycle;
    - to_master<=gnt;
    - to_count increments, saturating at all-ones;
    - the counter clears;
    - arbitration runs with the exclusion rule above.
  - bus_ack in the same cycle as the limit: ack wins, no timeout.
  - With TIMEOUT=0 the counter is tied to 0 and bus_err is never asserted.
- to_clr has priority over a simultaneous timeout increment: to_count=0 and to_master=0. bus_err still pulses.
- Request bits whose index is >= NUM_MASTERS do not exist. gnt never takes a value >= NUM_MASTERS.
- Reset asserted mid-transaction returns all state to reset values asynchronously. After release, gnt=0 regardless of req.

Decomposition:
- Shared package/include holds:
  - the gnt width function (clog2);
  - the round-robin next-index function;
  - default TIMEOUT and CNT_W constants, reused by the conbus top levels.
- One natural sub-module, conbus_rr_pick: a purely combinational rotate-priority-encoder taking req, the current index and an exclude bit, and returning the next index and a found flag.
- Watchdog and counters stay in the top.

Test Plan:
- Reset, req=5'b00000 -> gnt=0, gnt_oh=5'b00001, bus_err=0, to_count=0; req stays low for 10 cycles -> gnt stays 0.
- gnt=0, req=5'b10110, master 0 idle -> gnt sequence 1,2,4,1 as each owner drops cyc for one cycle; each change lands 1 cycle after the drop.
- Master 2 owns, 8-beat burst with a 3-cycle stb gap mid-burst, req[3] high throughout -> gnt stays 2 until req[2]=0, then 3.
- TIMEOUT=16, master 1 owns, stb high, no ack -> bus_err pulses on the edge ending cycle 16; to_master=1; to_count=1; req=5'b00011 -> gnt=0. With req=5'b00010 -> gnt stays 1 and the watchdog restarts.
- TIMEOUT=16, bus_ack arrives in the 16th wait cycle -> no bus_err, to_count unchanged.
- Force 0xFFFF timeouts (CNT_W=16) then one more -> to_count stays 0xFFFF. Then to_clr coincident with a timeout -> to_count=0, bus_err=1. Then sys_rst_n pulse mid-burst -> gnt=0 immediately.
